pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the RV32 core. It arbitrates PC redirects (jump and trap) and multiple stall requesters, and drives per-stage hold and flush vectors. A redirect arriving while the redirecting stage is stalled is captured and issued on stall release. After each redirect it inserts a programmable number of fetch bubbles. It sits between the execute/CSR units and the PC, pipeline registers and bus masters.

## Interface
- ADDR_W, 32, PC/redirect address width
- NSTAGE, 3, pipeline stages; stage 0 = PC/fetch, stage NSTAGE-1 = execute (redirect source)
- NHOLD, 4, number of stall requesters
- FLUSH_CYC, 2, stage-0 bubble cycles per redirect, including the issue cycle (≥1)
- SW (localparam), $clog2(NSTAGE) (min 1), hold level field width

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- jump_flag_i  in  1  jump/branch-taken request from execute
- jump_addr_i  in  ADDR_W  jump target
- trap_flag_i  in  1  trap/interrupt request; takes priority over jump
- trap_addr_i  in  ADDR_W  trap vector
- hold_req_i  in  NHOLD  per-requester stall request
- hold_lvl_i  in  NHOLD*SW  per-requester level L; stalls stages 0..L (values ≥ NSTAGE clamp to NSTAGE-1)
- jump_flag_o  out  1  PC redirect strobe, one cycle per issued redirect
- jump_addr_o  out  ADDR_W  redirect target, valid with jump_flag_o, else 0
- hold_o  out  NSTAGE  stage i stalled
- flush_o  out  NSTAGE  stage i output replaced by bubble
- busy_o  out  1  state ≠ RUN

## Operation
- Raw hold: hraw[i] = OR over k of (hold_req_i[k] & lvl_k ≥ i). hraw is monotonic: hraw[i] implies hraw[j] for all j<i.
- Request select: trap_flag_i beats jump_flag_i. The selected input is `req`, with its target.
- States RUN, PEND, FLUSH. Registers: state, pend_valid, pend_is_trap, pend_addr, cnt (width ≥ $clog2(FLUSH_CYC+1)).
- Issue condition: a request (pending or new) exists and hraw[NSTAGE-1]=0.
- Issue-cycle priority: new trap > pending trap > pending jump > new jump.
- Issue cycle outputs:
  - jump_flag_o=1; jump_addr_o = winner target.
  - flush_o[NSTAGE-2:0] all 1; flush_o[NSTAGE-1]=0.
  - hold_o[NSTAGE-2:0] forced 0, so the redirect overrides lower stalls.
  - Next state: cnt←FLUSH_CYC-1, pend cleared, state←FLUSH if FLUSH_CYC>1, else RUN.
- RUN/FLUSH, request present, hraw[NSTAGE-1]=1:
  - Latch the request into pend and go to PEND.
  - jump_flag_o=0, hold_o=hraw.
- PEND:
  - A new trap overwrites a pending jump.
  - A new jump never overwrites a pending request.
  - Stay in PEND until the issue condition holds.
- FLUSH (no issue this cycle):
  - flush_o[0]=1, hold_o=hraw.
  - cnt decrements only when hraw[0]=0. It freezes while stage 0 is held.
  - cnt=1 with a decrement → RUN.
- FLUSH with a new request: the request is issued (or pended) per the rules above, and the issue restarts cnt.
- Outside an issue cycle: hold_o=hraw; flush_o=0 except flush_o[0] in FLUSH.
- busy_o = (state≠RUN).

## Timing
- Redirect latency when not stalled: 0 cycles, combinational from the flag to jump_flag_o (same cycle).
- Pended redirect: issued in the first cycle with hraw[NSTAGE-1]=0, from registers. Latency = stall cycles.
- Hold latency: 0 cycles, combinational.
- Bubbles: stage-0 flush is asserted for FLUSH_CYC cycles in which stage 0 is not held, counting the issue cycle.
- Reset:
  - While rst=1, all outputs are 0: jump_flag_o, jump_addr_o, hold_o, flush_o, busy_o.
  - state=RUN, pend cleared, cnt=0.
  - Reset mid-PEND or mid-FLUSH discards the pending redirect and remaining bubbles.
- First cycle after reset release: behaves as RUN.

## Test plan
- Plain jump (defaults): jump_flag_i=1, jump_addr_i=0x100, no holds.
  - Same cycle: jump_flag_o=1, addr 0x100, flush_o=3'b011.
  - Next cycle: flush_o=3'b001, busy_o=1.
  - Cycle after that: flush_o=0, busy_o=0.
- Deferred jump: hold_req_i[1]=1 with lvl 2 for 3 cycles; jump 0x200 asserted for 1 cycle in the first stalled cycle.
  - hold_o=3'b111 throughout; busy_o=1.
  - On the release cycle: jump_flag_o=1, addr 0x200.
- Trap priority:
  - Jump 0x300 and trap 0x8 in the same cycle → addr 0x8.
  - Pending jump 0x400, then trap 0x10 during the stall → only 0x10 issues on release, one strobe.
- Bubble freeze: after a redirect (FLUSH_CYC=2), hold_req_i[0]=1 with lvl 0 for 2 cycles.
  - flush_o[0] stays 1 until one unheld post-issue cycle has elapsed: 4 cycles total from issue.
- Hold vector and clamp (NHOLD=4): lvl = {3, 0, 1, 2} (clamped to 2) with requesters 0 and 2 active → hold_o=3'b111. Only requester 2 active → 3'b001.
- Async reset: assert rst mid-PEND with no clock edge → outputs 0 immediately. After release with holds clear → no jump_flag_o and busy_o=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the RV32 core. Arbitrates trap/jump PC
// redirects against stall requesters, defers redirects blocked by an
// execute-stage stall, and inserts fetch bubbles after every redirect.
module pipe_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned NHOLD     = 4,
  parameter int unsigned FLUSH_CYC = 2,
  localparam int unsigned SW       = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_flag_i,
  input  logic [ADDR_W-1:0]   jump_addr_i,
  input  logic                trap_flag_i,
  input  logic [ADDR_W-1:0]   trap_addr_i,
  input  logic [NHOLD-1:0]    hold_req_i,
  input  logic [NHOLD*SW-1:0] hold_lvl_i,
  output logic                jump_flag_o,
  output logic [ADDR_W-1:0]   jump_addr_o,
  output logic [NSTAGE-1:0]   hold_o,
  output logic [NSTAGE-1:0]   flush_o,
  output logic                busy_o
);

  localparam int unsigned CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_is_trap_q, pend_is_trap_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NSTAGE-1:0] hraw;
  logic [SW-1:0]     lvl;
  logic              new_req;
  logic [ADDR_W-1:0] new_tgt;
  logic              jf_c;
  logic [ADDR_W-1:0] ja_c;
  logic [NSTAGE-1:0] hold_c;
  logic [NSTAGE-1:0] flush_c;

  // Raw stall vector: requester k stalls stages 0..clamp(lvl_k)
  always_comb begin
    hraw = '0;
    lvl  = '0;
    for (int unsigned k = 0; k < NHOLD; k++) begin
      lvl = hold_lvl_i[k*SW +: SW];
      if (32'(lvl) >= NSTAGE) lvl = SW'(NSTAGE - 1);
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        if (hold_req_i[k] && (32'(lvl) >= i)) hraw[i] = 1'b1;
      end
    end
  end

  assign new_req = trap_flag_i | jump_flag_i;
  assign new_tgt = trap_flag_i ? trap_addr_i : jump_addr_i;

  // Redirect arbitration, deferral and bubble counting
  always_comb begin
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_is_trap_d = pend_is_trap_q;
    pend_addr_d    = pend_addr_q;
    cnt_d          = cnt_q;
    jf_c           = 1'b0;
    ja_c           = '0;
    hold_c         = hraw;
    flush_c        = '0;
    if (state_q == FLUSH) flush_c[0] = 1'b1;

    if ((pend_valid_q || new_req) && !hraw[NSTAGE-1]) begin
      // Issue: a new trap wins, then whatever is pending, then a new jump.
      jf_c = 1'b1;
      if (trap_flag_i)       ja_c = trap_addr_i;
      else if (pend_valid_q) ja_c = pend_addr_q;
      else                   ja_c = jump_addr_i;
      flush_c = '0;
      for (int unsigned i = 0; i + 1 < NSTAGE; i++) begin
        flush_c[i] = 1'b1;
        hold_c[i]  = 1'b0;
      end
      cnt_d          = CW'(FLUSH_CYC - 1);
      pend_valid_d   = 1'b0;
      pend_is_trap_d = 1'b0;
      pend_addr_d    = '0;
      state_d        = (FLUSH_CYC > 1) ? FLUSH : RUN;
    end else if (pend_valid_q || new_req) begin
      // Execute stalled: capture the request; only a trap may replace a pending jump.
      if (!pend_valid_q) begin
        pend_valid_d   = 1'b1;
        pend_is_trap_d = trap_flag_i;
        pend_addr_d    = new_tgt;
      end else if (trap_flag_i && !pend_is_trap_q) begin
        pend_is_trap_d = 1'b1;
        pend_addr_d    = trap_addr_i;
      end
      state_d = PEND;
    end else if (state_q == FLUSH && !hraw[0]) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) state_d = RUN;
    end
  end

  // State and pending-redirect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pend_valid_q   <= 1'b0;
      pend_is_trap_q <= 1'b0;
      pend_addr_q    <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_is_trap_q <= pend_is_trap_d;
      pend_addr_q    <= pend_addr_d;
      cnt_q          <= cnt_d;
    end
  end

  // Outputs are combinational from inputs, so reset must mask them directly.
  assign jump_flag_o = jf_c & ~rst;
  assign jump_addr_o = rst ? '0 : ja_c;
  assign hold_o      = rst ? '0 : hold_c;
  assign flush_o     = rst ? '0 : flush_c;
  assign busy_o      = ~rst & (state_q != RUN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with default parameters.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        trap_flag_i = 1'b0;
  logic [31:0] trap_addr_i = '0;
  logic [3:0]  hold_req_i  = '0;
  logic [7:0]  hold_lvl_i  = '0;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_o;
  logic [2:0]  flush_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [39:0] sb[$];
  logic [39:0] obs;
  assign obs = {jump_flag_o, jump_addr_o, hold_o, flush_o, busy_o};

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic        tf;
    logic [31:0] ta;
    logic [3:0]  hr;
    logic [7:0]  hl;
    logic [39:0] exp;
  } row_t;

  pipe_ctrl #(.ADDR_W(32), .NSTAGE(3), .NHOLD(4), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
    .hold_req_i(hold_req_i), .hold_lvl_i(hold_lvl_i),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .hold_o(hold_o), .flush_o(flush_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk(logic jf, logic [31:0] a, logic [2:0] h,
                                     logic [2:0] f, logic b);
    return {jf, a, h, f, b};
  endfunction

  function automatic row_t r(logic jf, logic [31:0] ja, logic tf, logic [31:0] ta,
                             logic [3:0] hr, logic [7:0] hl, logic [39:0] exp);
    row_t x;
    x.jf = jf; x.ja = ja; x.tf = tf; x.ta = ta; x.hr = hr; x.hl = hl; x.exp = exp;
    return x;
  endfunction

  // Drive one cycle of stimulus after the falling edge and queue its expectation.
  task automatic cyc(input row_t rw);
    @(negedge clk);
    jump_flag_i = rw.jf; jump_addr_i = rw.ja;
    trap_flag_i = rw.tf; trap_addr_i = rw.ta;
    hold_req_i  = rw.hr; hold_lvl_i  = rw.hl;
    sb.push_back(rw.exp);
    #4;
  endtask

  task automatic test_reset();
    logic [39:0] exp;
    jump_flag_i = 1'b1; jump_addr_i = 32'h123; hold_req_i = 4'b0010; hold_lvl_i = 8'h08;
    sb.push_back(mk(0, 0, 3'b000, 3'b000, 0));
    #2;
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    jump_flag_i = 1'b0; jump_addr_i = '0; hold_req_i = '0; hold_lvl_i = '0;
  endtask

  task automatic test_plain_jump();
    row_t rows[3];
    logic [39:0] exp;
    rows[0] = r(1, 32'h100, 0, 0, 4'b0000, 8'h00, mk(1, 32'h100, 3'b000, 3'b011, 0));
    rows[1] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b001, 1));
    rows[2] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL plain_jump[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_deferred_jump();
    row_t rows[6];
    logic [39:0] exp;
    rows[0] = r(1, 32'h200, 0, 0, 4'b0010, 8'h08, mk(0, 0,       3'b111, 3'b000, 0));
    rows[1] = r(0, 0,       0, 0, 4'b0010, 8'h08, mk(0, 0,       3'b111, 3'b000, 1));
    rows[2] = r(0, 0,       0, 0, 4'b0010, 8'h08, mk(0, 0,       3'b111, 3'b000, 1));
    rows[3] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(1, 32'h200, 3'b000, 3'b011, 1));
    rows[4] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b001, 1));
    rows[5] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL deferred_jump[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_trap_priority();
    row_t rows[9];
    logic [39:0] exp;
    rows[0] = r(1, 32'h300, 1, 32'h8,  4'b0000, 8'h00, mk(1, 32'h8,  3'b000, 3'b011, 0));
    rows[1] = r(0, 0,       0, 0,      4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b001, 1));
    rows[2] = r(0, 0,       0, 0,      4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b000, 0));
    rows[3] = r(1, 32'h400, 0, 0,      4'b0010, 8'h08, mk(0, 0,      3'b111, 3'b000, 0));
    rows[4] = r(0, 0,       1, 32'h10, 4'b0010, 8'h08, mk(0, 0,      3'b111, 3'b000, 1));
    rows[5] = r(0, 0,       0, 0,      4'b0010, 8'h08, mk(0, 0,      3'b111, 3'b000, 1));
    rows[6] = r(0, 0,       0, 0,      4'b0000, 8'h00, mk(1, 32'h10, 3'b000, 3'b011, 1));
    rows[7] = r(0, 0,       0, 0,      4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b001, 1));
    rows[8] = r(0, 0,       0, 0,      4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL trap_priority[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_bubble_freeze();
    row_t rows[5];
    logic [39:0] exp;
    rows[0] = r(1, 32'h500, 0, 0, 4'b0000, 8'h00, mk(1, 32'h500, 3'b000, 3'b011, 0));
    rows[1] = r(0, 0,       0, 0, 4'b0001, 8'h00, mk(0, 0,       3'b001, 3'b001, 1));
    rows[2] = r(0, 0,       0, 0, 4'b0001, 8'h00, mk(0, 0,       3'b001, 3'b001, 1));
    rows[3] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b001, 1));
    rows[4] = r(0, 0,       0, 0, 4'b0000, 8'h00, mk(0, 0,       3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bubble_freeze[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_hold_clamp();
    row_t rows[5];
    logic [39:0] exp;
    // lvl = {3, 0, 1, 2} for requesters {3, 2, 1, 0}
    rows[0] = r(0, 0, 0, 0, 4'b0101, 8'hC6, mk(0, 0, 3'b111, 3'b000, 0));
    rows[1] = r(0, 0, 0, 0, 4'b0100, 8'hC6, mk(0, 0, 3'b001, 3'b000, 0));
    rows[2] = r(0, 0, 0, 0, 4'b1000, 8'hC6, mk(0, 0, 3'b111, 3'b000, 0));
    rows[3] = r(0, 0, 0, 0, 4'b0010, 8'hC6, mk(0, 0, 3'b011, 3'b000, 0));
    rows[4] = r(0, 0, 0, 0, 4'b0000, 8'hC6, mk(0, 0, 3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_clamp[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[4];
    logic [39:0] exp;
    rows[0] = r(1, 32'hA0, 0, 0, 4'b0000, 8'h00, mk(1, 32'hA0, 3'b000, 3'b011, 0));
    rows[1] = r(1, 32'hB0, 0, 0, 4'b0000, 8'h00, mk(1, 32'hB0, 3'b000, 3'b011, 1));
    rows[2] = r(0, 0,      0, 0, 4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b001, 1));
    rows[3] = r(0, 0,      0, 0, 4'b0000, 8'h00, mk(0, 0,      3'b000, 3'b000, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[2];
    row_t post[2];
    logic [39:0] exp;
    rows[0] = r(1, 32'h600, 0, 0, 4'b0010, 8'h08, mk(0, 0, 3'b111, 3'b000, 0));
    rows[1] = r(0, 0,       0, 0, 4'b0010, 8'h08, mk(0, 0, 3'b111, 3'b000, 1));
    foreach (rows[i]) begin
      cyc(rows[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL async_reset_setup[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    // Reset between clock edges while pending and still stalled.
    @(negedge clk);
    jump_flag_i = 1'b1; jump_addr_i = 32'h700;
    #1 rst = 1'b1;
    sb.push_back(mk(0, 0, 3'b000, 3'b000, 0));
    #1;
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_reset_mid_pend: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    jump_flag_i = 1'b0; jump_addr_i = '0; hold_req_i = '0; hold_lvl_i = '0;
    sb.push_back(mk(0, 0, 3'b000, 3'b000, 0));
    #4;
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_reset_release: got %h expected %h", obs, exp);
    end
    post[0] = r(0, 0, 0, 0, 4'b0000, 8'h00, mk(0, 0, 3'b000, 3'b000, 0));
    post[1] = r(1, 32'h44, 0, 0, 4'b0000, 8'h00, mk(1, 32'h44, 3'b000, 3'b011, 0));
    foreach (post[i]) begin
      cyc(post[i]);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL async_reset_after[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_jump();
    test_deferred_jump();
    test_trap_priority();
    test_bubble_freeze();
    test_hold_clamp();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
